multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Control unit for the multi-cycle RISC-V core, extending the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback over several cycles. The datapath shares one ALU and one unified memory port. Memory access uses a ready handshake, so the core tolerates variable-latency memory. It sits between the instruction register and the datapath mux/enable controls; the separate ALU-control decoder still consumes `alu_op`.

## Interface
- `ENABLE_JALR`, default 1: decode opcode 1100111 (jalr); when 0 it is illegal.
- `ENABLE_LUI`, default 1: decode opcode 0110111 (lui); when 0 it is illegal.
- `MEM_HANDSHAKE`, default 1: when 1, memory states wait for `mem_ready`; when 0, `mem_ready` is ignored and treated as 1.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  7  opcode field from the instruction register.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completed the current request this cycle.
- `mem_req`  out  1  memory access request.
- `mem_write`  out  1  the request is a write.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load instruction register and oldPC.
- `pc_write`  out  1  PC load enable.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  2  00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
- `alu_src_b`  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- `result_src`  out  2  00 = ALUOut, 01 = read data, 10 = ALU result.
- `imm_src`  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `illegal_op`  out  1  one-cycle pulse on an undecodable opcode.

## Operation
- Moore FSM with internal signals `branch` and `pc_update`. The output `pc_write` = `pc_update` | (`branch` & `zero`).
- `imm_src` is combinational from `op` in every state: lw, addi-class and jalr use I; sw uses S; beq uses B; jal uses J; lui uses U; any other opcode gives 000.
- Per-state outputs and transitions:
  - FETCH: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10. `ir_write` and `pc_update` are asserted only when `mem_ready`. Advance to DECODE on `mem_ready`, else hold.
  - DECODE: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00, computing the branch/jal target. Next state by `op`: lw/sw→MEMADR, R→EXECUTER, I-ALU→EXECUTEI, beq→BEQ, jal→JAL, jalr→JALR, lui→LUI. Any other opcode pulses `illegal_op` and returns to FETCH.
  - MEMADR: a=10, b=01, alu_op=00. Next is MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: `mem_req`=1, `adr_src`=1. Wait for `mem_ready`, then go to MEMWB.
  - MEMWB: `result_src`=01, `reg_write`=1. Next is FETCH.
  - MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1. Wait for `mem_ready`, then go to FETCH.
  - EXECUTER: a=10, b=00, alu_op=10. Next is ALUWB.
  - EXECUTEI: a=10, b=01, alu_op=10. Next is ALUWB.
  - ALUWB: `result_src`=00, `reg_write`=1. Next is FETCH.
  - BEQ: a=10, b=00, alu_op=01, `result_src`=00, `branch`=1. Next is FETCH.
  - JAL: a=01, b=10, alu_op=00, `result_src`=00, `pc_update`=1. Next is ALUWB.
  - JALR: a=10, b=01, alu_op=00. Next is JAL. The datapath clears bit 0 of the target.
  - LUI: a=11, b=01, alu_op=00. Next is ALUWB.
- Default values in every state: all strobes are 0 and all selects are 00.

## Timing
- Cycles with zero memory wait: lw 5, sw 4, R 4, I-ALU 4, jalr 5, jal 4, lui 4, beq 3, illegal 2.
- Each cycle that `mem_ready` is low in FETCH, MEMREAD or MEMWRITE adds one cycle. `mem_req` and the address select stay stable while waiting.
- The memory handshake completes on the rising edge where `mem_req` & `mem_ready` are both high.
- `mem_ready` outside a memory state is ignored.
- Reset:
  - `rst_n` low puts the state in FETCH immediately.
  - While `rst_n` is low, `mem_req`, `mem_write`, `ir_write`, `pc_write`, `reg_write` and `illegal_op` are forced to 0.
  - While `rst_n` is low, the selects hold their FETCH values: `alu_src_a` 00, `alu_src_b` 10, `alu_op` 00, `result_src` 10, `adr_src` 0.
  - Asserting reset in the middle of an instruction abandons it, with no writeback.
  - The first fetch request is issued in the first cycle after `rst_n` rises.
- `pc_write` in BEQ is combinational on `zero` from the same cycle.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - the opcode constants;
  - the state enum;
  - the `imm_src`, `alu_src_a`, `alu_src_b`, `result_src` and `alu_op` encodings.
- Natural sub-module: `imm_src_decoder`, the combinational map from `op` to `imm_src` plus the opcode-legal flag. It is parameterised by `ENABLE_JALR` and `ENABLE_LUI`.

## Test plan
- lw with `mem_ready` tied to 1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `reg_write`=1 only in cycle 5 with `result_src`=01.
- sw with `mem_ready` low for 3 cycles in MEMWRITE → `mem_req`=1, `mem_write`=1 and `adr_src`=1 are held for 4 cycles; total 7 cycles; `reg_write` never asserts.
- beq in BEQ state → with `zero`=1, `pc_write`=1; with `zero`=0, `pc_write`=0. Both cases take 3 cycles.
- jalr → FETCH, DECODE, JALR, JAL, ALUWB. `pc_write`=1 in JAL; `imm_src`=000.
- `op`=1111111, then lui with `ENABLE_LUI`=0 → `illegal_op` pulses in DECODE for each, and the FSM is back in FETCH on the next cycle.
- `rst_n` dropped in MEMREAD → all strobes are 0 at once. After release, FETCH asserts `mem_req` and there is no `reg_write`.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit.
// Holds the decoded opcode constants, the controller state encoding and the
// encodings of every datapath select driven by the controller.
package riscv_ctrl_pkg;

    // Opcode field values recognised by the controller
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECUTER = 4'd6,
        ST_EXECUTEI = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BEQ      = 4'd9,
        ST_JAL      = 4'd10,
        ST_JALR     = 4'd11,
        ST_LUI      = 4'd12
    } state_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        SRC_A_PC    = 2'b00,
        SRC_A_OLDPC = 2'b01,
        SRC_A_RS1   = 2'b10,
        SRC_A_ZERO  = 2'b11
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_RDATA  = 2'b01,
        RES_ALU    = 2'b10
    } result_src_e;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Bundle between the multi-cycle controller and the datapath / memory port.
//   op, zero, mem_ready         : status from instruction register, ALU, memory
//   mem_req, mem_write, adr_src : unified memory port request and address select
//   ir_write, pc_write, reg_write, illegal_op : datapath strobes
//   alu_src_a/b, alu_op, result_src, imm_src  : datapath selects
// master = controller side, slave = datapath side.
interface multicycle_control_fsm_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic       illegal_op;

    modport master (
        input  op, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal_op
    );

    modport slave (
        output op, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal_op
    );
endinterface

// File: rtl/imm_src_decoder.sv
// Combinational opcode decoder: immediate format select plus opcode-legal flag.
//   op       in  7  opcode field
//   imm_src  out 3  immediate format (I/S/B/J/U); unknown or disabled opcodes give I
//   op_legal out 1  opcode is implemented in this configuration
module imm_src_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter bit ENABLE_JALR = 1'b1,
    parameter bit ENABLE_LUI  = 1'b1
) (
    input  logic [6:0] op,
    output logic [2:0] imm_src,
    output logic       op_legal
);

    // Map opcode to immediate format and legality
    always_comb begin
        imm_src  = IMM_I;
        op_legal = 1'b0;
        case (op)
            OP_LOAD, OP_ITYPE, OP_RTYPE: begin
                imm_src  = IMM_I;
                op_legal = 1'b1;
            end
            OP_STORE: begin
                imm_src  = IMM_S;
                op_legal = 1'b1;
            end
            OP_BEQ: begin
                imm_src  = IMM_B;
                op_legal = 1'b1;
            end
            OP_JAL: begin
                imm_src  = IMM_J;
                op_legal = 1'b1;
            end
            OP_JALR: begin
                imm_src  = IMM_I;
                op_legal = ENABLE_JALR;
            end
            OP_LUI: begin
                // a disabled lui decodes like any unknown opcode
                if (ENABLE_LUI) begin
                    imm_src  = IMM_U;
                    op_legal = 1'b1;
                end else begin
                    imm_src  = IMM_I;
                    op_legal = 1'b0;
                end
            end
            default: begin
                imm_src  = IMM_I;
                op_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RISC-V control unit. Sequences each instruction through
// fetch/decode/execute/memory/writeback, sharing one ALU and one memory port
// with a ready handshake.
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset; forces FETCH and blanks all strobes
//   bus   master side of multicycle_control_fsm_if (status in, controls out)
// Parameters: ENABLE_JALR, ENABLE_LUI enable those opcodes; MEM_HANDSHAKE=0
// treats mem_ready as permanently high.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter bit ENABLE_JALR   = 1'b1,
    parameter bit ENABLE_LUI    = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    multicycle_control_fsm_if.master        bus
);

    state_e      state_r;
    state_e      state_next_s;
    logic        mem_ready_s;
    logic        op_legal_s;
    logic [2:0]  imm_src_s;
    logic        mem_req_s;
    logic        mem_write_s;
    logic        adr_src_s;
    logic        ir_write_s;
    logic        pc_update_s;
    logic        branch_s;
    logic        reg_write_s;
    logic        illegal_op_s;
    alu_src_a_e  alu_src_a_s;
    alu_src_b_e  alu_src_b_s;
    alu_op_e     alu_op_s;
    result_src_e result_src_s;

    imm_src_decoder #(
        .ENABLE_JALR (ENABLE_JALR),
        .ENABLE_LUI  (ENABLE_LUI)
    ) u_imm_src_decoder (
        .op       (bus.op),
        .imm_src  (imm_src_s),
        .op_legal (op_legal_s)
    );

    assign mem_ready_s = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    // State register; reset lands in FETCH so the first request follows release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and Moore outputs per state
    always_comb begin
        state_next_s = state_r;
        mem_req_s    = 1'b0;
        mem_write_s  = 1'b0;
        adr_src_s    = 1'b0;
        ir_write_s   = 1'b0;
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        reg_write_s  = 1'b0;
        illegal_op_s = 1'b0;
        alu_src_a_s  = SRC_A_PC;
        alu_src_b_s  = SRC_B_RS2;
        alu_op_s     = ALU_ADD;
        result_src_s = RES_ALUOUT;
        case (state_r)
            ST_FETCH: begin
                mem_req_s    = 1'b1;
                alu_src_b_s  = SRC_B_FOUR;
                result_src_s = RES_ALU;
                // IR and PC+4 are only captured once the instruction word arrives
                if (mem_ready_s) begin
                    ir_write_s   = 1'b1;
                    pc_update_s  = 1'b1;
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                // ALU precomputes oldPC + imm for beq / jal
                alu_src_a_s = SRC_A_OLDPC;
                alu_src_b_s = SRC_B_IMM;
                if (!op_legal_s) begin
                    illegal_op_s = 1'b1;
                    state_next_s = ST_FETCH;
                end else begin
                    case (bus.op)
                        OP_LOAD, OP_STORE: state_next_s = ST_MEMADR;
                        OP_RTYPE:          state_next_s = ST_EXECUTER;
                        OP_ITYPE:          state_next_s = ST_EXECUTEI;
                        OP_BEQ:            state_next_s = ST_BEQ;
                        OP_JAL:            state_next_s = ST_JAL;
                        OP_JALR:           state_next_s = ST_JALR;
                        OP_LUI:            state_next_s = ST_LUI;
                        default:           state_next_s = ST_FETCH;
                    endcase
                end
            end
            ST_MEMADR: begin
                alu_src_a_s = SRC_A_RS1;
                alu_src_b_s = SRC_B_IMM;
                if (bus.op == OP_STORE) begin
                    state_next_s = ST_MEMWRITE;
                end else begin
                    state_next_s = ST_MEMREAD;
                end
            end
            ST_MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
                if (mem_ready_s) begin
                    state_next_s = ST_MEMWB;
                end else begin
                    state_next_s = ST_MEMREAD;
                end
            end
            ST_MEMWB: begin
                result_src_s = RES_RDATA;
                reg_write_s  = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_MEMWRITE: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                adr_src_s   = 1'b1;
                if (mem_ready_s) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_MEMWRITE;
                end
            end
            ST_EXECUTER: begin
                alu_src_a_s  = SRC_A_RS1;
                alu_src_b_s  = SRC_B_RS2;
                alu_op_s     = ALU_FUNCT;
                state_next_s = ST_ALUWB;
            end
            ST_EXECUTEI: begin
                alu_src_a_s  = SRC_A_RS1;
                alu_src_b_s  = SRC_B_IMM;
                alu_op_s     = ALU_FUNCT;
                state_next_s = ST_ALUWB;
            end
            ST_ALUWB: begin
                result_src_s = RES_ALUOUT;
                reg_write_s  = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_BEQ: begin
                alu_src_a_s  = SRC_A_RS1;
                alu_src_b_s  = SRC_B_RS2;
                alu_op_s     = ALU_SUB;
                result_src_s = RES_ALUOUT;
                branch_s     = 1'b1;
                state_next_s = ST_FETCH;
            end
            ST_JAL: begin
                // ALUOut holds the target; ALU forms the link value oldPC + 4
                alu_src_a_s  = SRC_A_OLDPC;
                alu_src_b_s  = SRC_B_FOUR;
                alu_op_s     = ALU_ADD;
                result_src_s = RES_ALUOUT;
                pc_update_s  = 1'b1;
                state_next_s = ST_ALUWB;
            end
            ST_JALR: begin
                // rs1 + imm overwrites ALUOut, then JAL reuses the jump path
                alu_src_a_s  = SRC_A_RS1;
                alu_src_b_s  = SRC_B_IMM;
                state_next_s = ST_JAL;
            end
            ST_LUI: begin
                alu_src_a_s  = SRC_A_ZERO;
                alu_src_b_s  = SRC_B_IMM;
                state_next_s = ST_ALUWB;
            end
            default: begin
                state_next_s = ST_FETCH;
            end
        endcase
    end

    // Strobes are blanked while reset is held; the selects already show FETCH values
    assign bus.mem_req    = rst_n & mem_req_s;
    assign bus.mem_write  = rst_n & mem_write_s;
    assign bus.ir_write   = rst_n & ir_write_s;
    assign bus.pc_write   = rst_n & (pc_update_s | (branch_s & bus.zero));
    assign bus.reg_write  = rst_n & reg_write_s;
    assign bus.illegal_op = rst_n & illegal_op_s;
    assign bus.adr_src    = adr_src_s;
    assign bus.alu_src_a  = alu_src_a_s;
    assign bus.alu_src_b  = alu_src_b_s;
    assign bus.alu_op     = alu_op_s;
    assign bus.result_src = result_src_s;
    assign bus.imm_src    = imm_src_s;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm. Two instances: dut_a with all features and
// the memory handshake, dut_b with jalr/lui disabled and the handshake off.
// The reference model describes each instruction as its list of steps and
// each step as its control word.
module tb_multicycle_control_fsm;

    localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5;
    localparam int S_ER = 6, S_EI = 7, S_AWB = 8, S_BEQ = 9, S_JAL = 10;
    localparam int S_JALR = 11, S_LUI = 12, S_RST = 13, S_END = 14;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_fsm_if bus_a ();
    multicycle_control_fsm_if bus_b ();

    multicycle_control_fsm #(.ENABLE_JALR(1'b1), .ENABLE_LUI(1'b1), .MEM_HANDSHAKE(1'b1)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (bus_a.master));
    multicycle_control_fsm #(.ENABLE_JALR(1'b0), .ENABLE_LUI(1'b0), .MEM_HANDSHAKE(1'b0)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (bus_b.master));

    logic [17:0] obs [2];
    assign obs[0] = {bus_a.mem_req, bus_a.mem_write, bus_a.adr_src, bus_a.ir_write, bus_a.pc_write,
                     bus_a.reg_write, bus_a.alu_src_a, bus_a.alu_src_b, bus_a.alu_op,
                     bus_a.result_src, bus_a.imm_src, bus_a.illegal_op};
    assign obs[1] = {bus_b.mem_req, bus_b.mem_write, bus_b.adr_src, bus_b.ir_write, bus_b.pc_write,
                     bus_b.reg_write, bus_b.alu_src_a, bus_b.alu_src_b, bus_b.alu_op,
                     bus_b.result_src, bus_b.imm_src, bus_b.illegal_op};

    bit         en_jalr [2];
    bit         en_lui  [2];
    bit         hs      [2];
    logic [6:0] cur_op  [2];
    logic [6:0] next_op [2];
    int         pos     [2];
    bit         need_new[2];
    bit         rand_op [2];
    bit         rand_in [2];
    logic       mr      [2];
    logic       zr      [2];
    int         total = 0;
    int         bad   = 0;

    function automatic bit ref_legal(input logic [6:0] o, input bit ej, input bit el);
        case (o)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111: return 1'b1;
            7'b1100111: return ej;
            7'b0110111: return el;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] ref_imm(input logic [6:0] o, input bit el);
        case (o)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            7'b0110111: return el ? 3'b100 : 3'b000;
            default:    return 3'b000;
        endcase
    endfunction

    // i-th step of an instruction, S_END past its last step
    function automatic int step_at(input logic [6:0] o, input bit ej, input bit el, input int i);
        int s [5];
        s = '{S_F, S_D, S_END, S_END, S_END};
        if (ref_legal(o, ej, el)) begin
            case (o)
                7'b0000011: s = '{S_F, S_D, S_MA, S_MR, S_MWB};
                7'b0100011: s = '{S_F, S_D, S_MA, S_MW, S_END};
                7'b0110011: s = '{S_F, S_D, S_ER, S_AWB, S_END};
                7'b0010011: s = '{S_F, S_D, S_EI, S_AWB, S_END};
                7'b1100011: s = '{S_F, S_D, S_BEQ, S_END, S_END};
                7'b1101111: s = '{S_F, S_D, S_JAL, S_AWB, S_END};
                7'b1100111: s = '{S_F, S_D, S_JALR, S_JAL, S_AWB};
                7'b0110111: s = '{S_F, S_D, S_LUI, S_AWB, S_END};
                default:    s = '{S_F, S_D, S_END, S_END, S_END};
            endcase
        end
        return (i < 5) ? s[i] : S_END;
    endfunction

    function automatic string step_name(input int st);
        case (st)
            S_F: return "fetch";     S_D: return "decode";   S_MA: return "memadr";
            S_MR: return "memread";  S_MWB: return "memwb";  S_MW: return "memwrite";
            S_ER: return "executer"; S_EI: return "executei"; S_AWB: return "aluwb";
            S_BEQ: return "beq";     S_JAL: return "jal";    S_JALR: return "jalr";
            S_LUI: return "lui";     S_RST: return "reset";  default: return "none";
        endcase
    endfunction

    // Control word {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,a,b,alu_op,result,imm,illegal}
    function automatic logic [17:0] exp_vec(input int st, input logic [6:0] o, input logic z,
                                            input logic mre, input bit ej, input bit el);
        logic mreq, mwr, adr, irw, pcw, rw, ill;
        logic [1:0] a, b, aop, res;
        mreq = 1'b0; mwr = 1'b0; adr = 1'b0; irw = 1'b0; pcw = 1'b0; rw = 1'b0; ill = 1'b0;
        a = 2'b00; b = 2'b00; aop = 2'b00; res = 2'b00;
        case (st)
            S_F:    begin mreq = 1'b1; b = 2'b10; res = 2'b10; irw = mre; pcw = mre; end
            S_D:    begin a = 2'b01; b = 2'b01; ill = ~ref_legal(o, ej, el); end
            S_MA:   begin a = 2'b10; b = 2'b01; end
            S_MR:   begin mreq = 1'b1; adr = 1'b1; end
            S_MWB:  begin res = 2'b01; rw = 1'b1; end
            S_MW:   begin mreq = 1'b1; mwr = 1'b1; adr = 1'b1; end
            S_ER:   begin a = 2'b10; b = 2'b00; aop = 2'b10; end
            S_EI:   begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            S_AWB:  begin rw = 1'b1; end
            S_BEQ:  begin a = 2'b10; aop = 2'b01; pcw = z; end
            S_JAL:  begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
            S_JALR: begin a = 2'b10; b = 2'b01; end
            S_LUI:  begin a = 2'b11; b = 2'b01; end
            S_RST:  begin b = 2'b10; res = 2'b10; end
            default: begin mreq = 1'bx; end
        endcase
        return {mreq, mwr, adr, irw, pcw, rw, a, b, aop, res, ref_imm(o, el), ill};
    endfunction

    function automatic logic [6:0] rand_opcode();
        case ($urandom_range(0, 9))
            0: return 7'b0000011;
            1: return 7'b0100011;
            2: return 7'b0110011;
            3: return 7'b0010011;
            4: return 7'b1100011;
            5: return 7'b1101111;
            6: return 7'b1100111;
            7: return 7'b0110111;
            default: return 7'($urandom_range(0, 127));
        endcase
    endfunction

    task automatic chk(input string tag, input logic [17:0] o, input logic [17:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // Apply this cycle's inputs, then compare both instances at the falling edge
    task automatic pre();
        for (int k = 0; k < 2; k++) begin
            if (rst_n && need_new[k]) begin
                cur_op[k]   = rand_op[k] ? rand_opcode() : next_op[k];
                pos[k]      = 0;
                need_new[k] = 1'b0;
            end
            if (rand_in[k]) begin
                mr[k] = ($urandom_range(0, 2) != 0);
                zr[k] = 1'($urandom_range(0, 1));
            end
        end
        bus_a.op = cur_op[0]; bus_a.mem_ready = mr[0]; bus_a.zero = zr[0];
        bus_b.op = cur_op[1]; bus_b.mem_ready = mr[1]; bus_b.zero = zr[1];
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int   st;
            logic mre;
            st  = rst_n ? step_at(cur_op[k], en_jalr[k], en_lui[k], pos[k]) : S_RST;
            mre = hs[k] ? mr[k] : 1'b1;
            chk($sformatf("dut%0d_%s_op%b", k, step_name(st), cur_op[k]), obs[k],
                exp_vec(st, cur_op[k], zr[k], mre, en_jalr[k], en_lui[k]));
        end
    endtask

    // Advance the model across the rising edge
    task automatic post();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                need_new[k] = 1'b1;
            end else begin
                int st;
                st = step_at(cur_op[k], en_jalr[k], en_lui[k], pos[k]);
                if (!(hs[k] && !mr[k] && (st == S_F || st == S_MR || st == S_MW))) pos[k]++;
                if (step_at(cur_op[k], en_jalr[k], en_lui[k], pos[k]) == S_END) need_new[k] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        en_jalr = '{1'b1, 1'b0}; en_lui = '{1'b1, 1'b0}; hs = '{1'b1, 1'b0};
        cur_op  = '{7'd0, 7'd0}; next_op = '{7'b1111111, 7'b1111111};
        pos = '{0, 0}; need_new = '{1'b1, 1'b1};
        rand_op = '{1'b0, 1'b0}; rand_in = '{1'b0, 1'b1};
        mr = '{1'b1, 1'b1}; zr = '{1'b0, 1'b0};
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // reset held: strobes low, FETCH selects
        for (int i = 0; i < 2; i++) begin
            pre();
            chk("reset_mem_req", 18'(bus_a.mem_req), 18'd0);
            post();
        end
        rst_n = 1'b1;

        // 1111111 on both, then lui on the lui-disabled instance
        for (int i = 0; i < 4; i++) begin
            if (i == 2) next_op[1] = 7'b0110111;
            pre();
            if (i % 2 == 1) begin
                chk("illegal_a", 18'(bus_a.illegal_op), 18'd1);
                chk("illegal_b", 18'(bus_b.illegal_op), 18'd1);
            end else begin
                chk("fetch_strobes", 18'({bus_a.mem_req, bus_a.illegal_op, bus_b.mem_req, bus_b.illegal_op}),
                    18'b1010);
            end
            post();
        end
        rand_op[1] = 1'b1;

        // lw, memory always ready
        next_op[0] = 7'b0000011;
        for (int i = 0; i < 5; i++) begin
            pre();
            chk("lw_reg_write", 18'(bus_a.reg_write), 18'(i == 4));
            if (i == 4) chk("lw_result_src", 18'(bus_a.result_src), 18'b01);
            post();
        end

        // sw with three wait cycles in MEMWRITE
        next_op[0] = 7'b0100011;
        for (int i = 0; i < 7; i++) begin
            mr[0] = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
            pre();
            chk("sw_reg_write", 18'(bus_a.reg_write), 18'd0);
            if (i >= 3) chk("sw_mem_strobes", 18'({bus_a.mem_req, bus_a.mem_write, bus_a.adr_src}), 18'b111);
            post();
        end
        mr[0] = 1'b1;

        // beq taken then not taken
        for (int t = 0; t < 2; t++) begin
            next_op[0] = 7'b1100011;
            zr[0] = (t == 0);
            for (int i = 0; i < 3; i++) begin
                pre();
                if (i == 2) chk("beq_pc_write", 18'(bus_a.pc_write), 18'(t == 0));
                post();
            end
        end
        zr[0] = 1'b0;

        // jalr
        next_op[0] = 7'b1100111;
        for (int i = 0; i < 5; i++) begin
            pre();
            chk("jalr_imm_src", 18'(bus_a.imm_src), 18'd0);
            if (i == 3) chk("jalr_pc_write", 18'(bus_a.pc_write), 18'd1);
            post();
        end

        // reset dropped while lw stalls in MEMREAD
        next_op[0] = 7'b0000011;
        for (int i = 0; i < 4; i++) begin
            mr[0] = (i < 3);
            pre();
            post();
        end
        rst_n = 1'b0;
        mr[0] = 1'b1;
        pre();
        chk("rst_strobes", 18'({bus_a.mem_req, bus_a.mem_write, bus_a.ir_write, bus_a.pc_write,
                                bus_a.reg_write, bus_a.illegal_op}), 18'd0);
        chk("rst_selects", 18'({bus_a.alu_src_a, bus_a.alu_src_b, bus_a.alu_op, bus_a.result_src,
                                bus_a.adr_src}), 18'b00_10_00_10_0);
        post();
        rst_n = 1'b1;
        next_op[0] = 7'b0110011;
        pre();
        chk("post_rst_fetch", 18'({bus_a.mem_req, bus_a.reg_write}), 18'b10);
        post();

        // random instructions, memory latency, zero flag and occasional reset
        rand_op = '{1'b1, 1'b1};
        rand_in = '{1'b1, 1'b1};
        for (int c = 0; c < 1500; c++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            pre();
            post();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
